sseg_scanner: RTL

SSEG_SCANNER -- requirements
Module: sseg_scanner

---
 rtl/sseg_scanner.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/sseg_scanner.sv
// sseg_scanner: multiplexed seven-segment display driver.
//
// Scans NUM_DIGITS digits, one per slot of SLOT_CYCLES clocks. At each frame
// start (first slot of digit 0) the selected source word, decimal points and
// the leading-zero blanking enable are captured, so a frame is always drawn
// from one consistent snapshot. Brightness is applied live through a 16-step
// PWM and gates the active anode and the decimal point.
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous active-low reset
//   display_sel  source select; out-of-range values select source 0
//   display_bus  concatenated sources, source k at [k*4*NUM_DIGITS +: 4*NUM_DIGITS]
//   dp_in        decimal point request per digit (1 = lit)
//   blank_lz     leading-zero blanking enable
//   brightness   PWM duty, 0 = dark, 15 = full on
//   anode        active-low digit enables (at most one low)
//   cathode      active-low segments {g,f,e,d,c,b,a}
//   dp           active-low decimal point
//   frame_tick   one-cycle pulse in the cycle after each frame start
module sseg_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int NUM_SOURCES = 2,
  parameter int SLOT_CYCLES = 100000,
  localparam int SW = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [SW-1:0]                       display_sel,
  input  logic [NUM_SOURCES*NUM_DIGITS*4-1:0] display_bus,
  input  logic [NUM_DIGITS-1:0]               dp_in,
  input  logic                                blank_lz,
  input  logic [3:0]                          brightness,
  output logic [NUM_DIGITS-1:0]               anode,
  output logic [6:0]                          cathode,
  output logic                                dp,
  output logic                                frame_tick
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(SLOT_CYCLES);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]         slot_cnt_q, slot_cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [3:0]            pwm_cnt_q;
  logic [DW-1:0]         word_q;
  logic [NUM_DIGITS-1:0] dpl_q;
  logic                  blz_q;
  logic                  frame_tick_q;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic [6:0]            cathode_q, cathode_d;
  logic                  dp_q, dp_d;

  logic                  slot_wrap;
  logic                  frame_start;
  logic [DW-1:0]         src_word;
  logic [NUM_DIGITS-1:0] blank;
  logic [3:0]            nib;
  logic                  bright;
  logic                  digit_blank;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] seg;
    case (v)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  assign slot_wrap   = (slot_cnt_q == SLOT_LAST);
  assign frame_start = (slot_cnt_q == '0) && (idx_q == '0);

  always_comb begin
    slot_cnt_d = slot_wrap ? '0 : slot_cnt_q + 1'b1;
    idx_d      = idx_q;
    if (slot_wrap) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // Unmatched select codes fall through to source 0.
  always_comb begin
    src_word = display_bus[0 +: DW];
    for (int k = 1; k < NUM_SOURCES; k++) begin
      if (display_sel == SW'(k)) src_word = display_bus[k*DW +: DW];
    end
  end

  // Walk from the top digit down; a digit is blanked while every nibble from
  // the top down to and including it is zero. Digit 0 always shows.
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    blank    = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (word_q[4*i +: 4] == 4'h0);
      if (i != 0) blank[i] = blz_q & zero_run;
    end
  end

  assign nib         = word_q[{idx_q, 2'b00} +: 4];
  assign digit_blank = blank[idx_q];
  assign bright      = (brightness == 4'hF) || (pwm_cnt_q < brightness);

  always_comb begin
    anode_d = '1;
    if (bright && !digit_blank) anode_d[idx_q] = 1'b0;
    cathode_d = digit_blank ? 7'h7F : hex7(nib);
    dp_d      = (digit_blank || !bright) ? 1'b1 : ~dpl_q[idx_q];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      slot_cnt_q   <= '0;
      idx_q        <= '0;
      pwm_cnt_q    <= '0;
      word_q       <= '0;
      dpl_q        <= '0;
      blz_q        <= 1'b0;
      frame_tick_q <= 1'b0;
      anode_q      <= '1;
      cathode_q    <= 7'h7F;
      dp_q         <= 1'b1;
    end else begin
      slot_cnt_q   <= slot_cnt_d;
      idx_q        <= idx_d;
      pwm_cnt_q    <= pwm_cnt_q + 1'b1;
      frame_tick_q <= frame_start;
      if (frame_start) begin
        word_q <= src_word;
        dpl_q  <= dp_in;
        blz_q  <= blank_lz;
      end
      anode_q   <= anode_d;
      cathode_q <= cathode_d;
      dp_q      <= dp_d;
    end
  end

  assign anode      = anode_q;
  assign cathode    = cathode_q;
  assign dp         = dp_q;
  assign frame_tick = frame_tick_q;

endmodule
